// File: rtl/pc_stack_reg.sv
// ---------------------------------------------------------------------------
// pc_stack_reg
//   Program-counter register for the fetch stage. The PC can hold, load,
//   increment by STEP, clear, or take a PC-relative jump. CALL and RET use
//   an internal LIFO return-address stack. The block also reports stack
//   status and two sticky error flags to the sequencer.
//
// Parameters
//   N      register / address width (>= 2)
//   STEP   increment amount, also the return-address offset pushed on CALL
//   DEPTH  return-stack entries (power of two, >= 2)
//
// Ports
//   clk    rising-edge clock
//   clr    asynchronous active-low reset
//   ctrl   operation select, sampled every rising edge:
//            000 HOLD   001 LOAD  010 INCR  011 CLEAR
//            100 REL    101 CALL  110 RET   111 FLUSH
//   in     load value / call target / signed relative offset
//   out    current PC (registered)
//   tos    top-of-stack entry, 0 when the stack is empty
//   count  number of valid stack entries
//   empty  count == 0
//   full   count == DEPTH
//   ovf    sticky: CALL attempted while full
//   unf    sticky: RET attempted while empty
//
// Handshake: none. ctrl and in are plain level inputs that must be stable
// around the rising edge. Every operation completes on that edge.
// ---------------------------------------------------------------------------
module pc_stack_reg #(
    parameter  int N     = 8,
    parameter  int STEP  = 1,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [2:0]    ctrl,
    input  logic [N-1:0]  in,
    output logic [N-1:0]  out,
    output logic [N-1:0]  tos,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_INCR  = 3'b010;
    localparam logic [2:0] OP_CLEAR = 3'b011;
    localparam logic [2:0] OP_REL   = 3'b100;
    localparam logic [2:0] OP_CALL  = 3'b101;
    localparam logic [2:0] OP_RET   = 3'b110;
    localparam logic [2:0] OP_FLUSH = 3'b111;

    localparam logic [N-1:0]  STEP_N  = N'(STEP);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [N-1:0]  out_q,   out_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q,   ovf_d;
    logic          unf_q,   unf_d;
    logic [N-1:0]  stack_q [DEPTH];

    logic          push_en;
    logic [N-1:0]  push_val;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic          is_empty;
    logic          is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);

    // The next free slot is indexed by count. The top entry sits one below
    // it. When the stack is full or empty the index wraps, but those cases
    // never write, and tos is masked, so the wrapped value is harmless.
    assign wr_idx = count_q[PW-1:0];
    assign rd_idx = PW'(count_q - ONE_C);

    always_comb begin
        out_d    = out_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        push_en  = 1'b0;
        push_val = out_q + STEP_N;
        case (ctrl)
            OP_HOLD:  ;
            OP_LOAD:  out_d = in;
            OP_INCR:  out_d = out_q + STEP_N;
            OP_CLEAR: out_d = '0;
            // Two's-complement add: the N-bit sum wraps the same way for
            // negative offsets as for positive ones.
            OP_REL:   out_d = out_q + in;
            OP_CALL: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    push_en = 1'b1;
                    out_d   = in;
                    count_d = count_q + ONE_C;
                end
            end
            OP_RET: begin
                if (is_empty) begin
                    unf_d = 1'b1;
                end else begin
                    out_d   = stack_q[rd_idx];
                    count_d = count_q - ONE_C;
                end
            end
            OP_FLUSH: begin
                count_d = '0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            out_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            out_q   <= out_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (push_en) begin
                stack_q[wr_idx] <= push_val;
            end
        end
    end

    assign out   = out_q;
    assign count = count_q;
    assign empty = is_empty;
    assign full  = is_full;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign tos   = is_empty ? '0 : stack_q[rd_idx];

endmodule

// File: tb/tb_pc_stack_reg.sv
module tb_pc_stack_reg;

    localparam int N  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);
    localparam int EW = N + CW + N + 4;

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_INCR  = 3'b010;
    localparam logic [2:0] OP_CLEAR = 3'b011;
    localparam logic [2:0] OP_REL   = 3'b100;
    localparam logic [2:0] OP_CALL  = 3'b101;
    localparam logic [2:0] OP_RET   = 3'b110;
    localparam logic [2:0] OP_FLUSH = 3'b111;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    // DUT 1: STEP = 1
    logic [2:0]    c1_ctrl = OP_HOLD;
    logic [N-1:0]  c1_in   = '0;
    logic [N-1:0]  d1_out, d1_tos;
    logic [CW-1:0] d1_count;
    logic          d1_empty, d1_full, d1_ovf, d1_unf;

    // DUT 2: STEP = 4
    logic [2:0]    c2_ctrl = OP_HOLD;
    logic [N-1:0]  c2_in   = '0;
    logic [N-1:0]  d2_out, d2_tos;
    logic [CW-1:0] d2_count;
    logic          d2_empty, d2_full, d2_ovf, d2_unf;

    pc_stack_reg #(.N(N), .STEP(1), .DEPTH(D)) u_dut1 (
        .clk(clk), .clr(clr), .ctrl(c1_ctrl), .in(c1_in),
        .out(d1_out), .tos(d1_tos), .count(d1_count),
        .empty(d1_empty), .full(d1_full), .ovf(d1_ovf), .unf(d1_unf)
    );

    pc_stack_reg #(.N(N), .STEP(4), .DEPTH(D)) u_dut2 (
        .clk(clk), .clr(clr), .ctrl(c2_ctrl), .in(c2_in),
        .out(d2_out), .tos(d2_tos), .count(d2_count),
        .empty(d2_empty), .full(d2_full), .ovf(d2_ovf), .unf(d2_unf)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (DUT 1) ----------------
    logic [N-1:0] m_out;
    logic [N-1:0] m_stk[$];
    logic         m_ovf, m_unf;

    task automatic model_reset();
        m_out = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] op, input logic [N-1:0] v);
        case (op)
            OP_LOAD:  m_out = v;
            OP_INCR:  m_out = m_out + 8'd1;
            OP_CLEAR: m_out = '0;
            OP_REL:   m_out = m_out + v;
            OP_CALL: begin
                if (m_stk.size() == D) m_ovf = 1'b1;
                else begin
                    m_stk.push_back(m_out + 8'd1);
                    m_out = v;
                end
            end
            OP_RET: begin
                if (m_stk.size() == 0) m_unf = 1'b1;
                else m_out = m_stk.pop_back();
            end
            OP_FLUSH: begin
                m_stk.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            default: ;
        endcase
    endtask

    function automatic logic [EW-1:0] model_pack();
        logic [N-1:0]  t;
        logic [CW-1:0] c;
        c = CW'(m_stk.size());
        t = (m_stk.size() == 0) ? '0 : m_stk[m_stk.size() - 1];
        return {m_out, c, t, (m_stk.size() == 0), (m_stk.size() == D), m_ovf, m_unf};
    endfunction

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [N-1:0]  exp2_q[$];

    task automatic compare_dut1(input string tag);
        logic [EW-1:0] e;
        check({tag, "_sb_avail"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_out"},   d1_out,   e[EW-1 -: N]);
            check({tag, "_count"}, d1_count, e[N+4+CW-1 -: CW]);
            check({tag, "_tos"},   d1_tos,   e[N+3 -: N]);
            check({tag, "_empty"}, d1_empty, e[3]);
            check({tag, "_full"},  d1_full,  e[2]);
            check({tag, "_ovf"},   d1_ovf,   e[1]);
            check({tag, "_unf"},   d1_unf,   e[0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive one op on DUT 1 (inputs change 1 time unit after an edge),
    // queue the model's prediction, and compare after the next edge.
    task automatic op1(input logic [2:0] op, input logic [N-1:0] v, input string tag);
        c1_ctrl = op;
        c1_in   = v;
        model_step(op, v);
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        compare_dut1(tag);
        c1_ctrl = OP_HOLD;
    endtask

    task automatic op2(input logic [2:0] op, input logic [N-1:0] v,
                       input logic [N-1:0] exp_out, input string tag);
        c2_ctrl = op;
        c2_in   = v;
        exp2_q.push_back(exp_out);
        @(posedge clk);
        #1;
        check({tag, "_sb_avail"}, exp2_q.size() > 0, 1);
        if (exp2_q.size() > 0) check(tag, d2_out, exp2_q.pop_front());
        c2_ctrl = OP_HOLD;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]   rop;
        logic [N-1:0] rin;

        model_reset();
        #1 clr = 1'b0;
        #1;
        exp_q.push_back(model_pack());
        compare_dut1("reset");
        check("reset_d2_out", d2_out, 0);
        repeat (2) @(posedge clk);
        #3 clr = 1'b1;

        // Reset / INCR wrap
        op1(OP_LOAD, 8'hFE, "load_fe");
        op1(OP_INCR, 8'h00, "incr1");
        check("tp_incr_ff", d1_out, 8'hFF);
        op1(OP_INCR, 8'h00, "incr2");
        check("tp_incr_wrap", d1_out, 8'h00);
        op1(OP_INCR, 8'h00, "incr3");
        check("tp_incr_01", d1_out, 8'h01);
        op1(OP_CALL, 8'h70, "pre_rst_call");

        // Asynchronous reset mid-sequence, between edges
        #3 clr = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(model_pack());
        compare_dut1("async_rst");
        check("tp_async_rst_out", d1_out, 8'h00);
        // Operations are ignored while clr is low
        c1_ctrl = OP_LOAD;
        c1_in   = 8'h55;
        @(posedge clk);
        #1;
        exp_q.push_back(model_pack());
        compare_dut1("rst_hold");
        c1_ctrl = OP_HOLD;
        #2 clr = 1'b1;

        // First op after release takes effect on the first edge
        op1(OP_LOAD, 8'h20, "first_after_rst");

        // Nested call/return
        op1(OP_CALL, 8'h40, "call40");
        op1(OP_CALL, 8'h60, "call60");
        check("tp_nest_count", d1_count, 2);
        check("tp_nest_tos", d1_tos, 8'h41);
        op1(OP_RET, 8'h00, "ret1");
        check("tp_ret1", d1_out, 8'h41);
        op1(OP_RET, 8'h00, "ret2");
        check("tp_ret2", d1_out, 8'h21);
        check("tp_ret2_empty", d1_empty, 1);

        // Overflow
        op1(OP_CLEAR, 8'h00, "clear");
        for (int i = 1; i <= 5; i++) begin
            op1(OP_CALL, N'(i * 16), "ovf_call");
            if (i == 4) begin
                check("tp_full4", d1_full, 1);
                check("tp_out4", d1_out, 8'h40);
            end
        end
        check("tp_ovf_out", d1_out, 8'h40);
        check("tp_ovf_count", d1_count, 4);
        check("tp_ovf_flag", d1_ovf, 1);
        op1(OP_INCR, 8'h00, "ovf_sticky");
        check("tp_ovf_sticky", d1_ovf, 1);
        op1(OP_FLUSH, 8'h00, "flush_ovf");

        // Underflow / flush
        op1(OP_LOAD, 8'h33, "load33");
        op1(OP_RET, 8'h00, "unf_ret");
        check("tp_unf_out", d1_out, 8'h33);
        check("tp_unf_flag", d1_unf, 1);
        op1(OP_FLUSH, 8'h00, "flush_unf");
        check("tp_flush_unf", d1_unf, 0);
        check("tp_flush_out", d1_out, 8'h33);

        // Back-to-back call/return
        op1(OP_LOAD, 8'h05, "load05");
        op1(OP_CALL, 8'h80, "b2b_call");
        op1(OP_RET, 8'h00, "b2b_ret");
        check("tp_b2b_out", d1_out, 8'h06);
        check("tp_b2b_count", d1_count, 0);
        op1(OP_LOAD, 8'h05, "load05b");
        op1(OP_CALL, 8'h80, "b2b_call2");
        op1(OP_CLEAR, 8'h00, "b2b_clear");
        check("tp_b2b_clear_count", d1_count, 1);
        op1(OP_RET, 8'h00, "b2b_ret2");
        check("tp_b2b_ret2", d1_out, 8'h06);

        // Randomised mix against the model
        for (int i = 0; i < 300; i++) begin
            rop = 3'($urandom_range(0, 7));
            if (rop == OP_FLUSH && $urandom_range(0, 3) != 0) rop = OP_CALL;
            rin = N'($urandom_range(0, 255));
            op1(rop, rin, "rand");
        end

        // STEP = 4 and relative jumps on DUT 2
        op2(OP_LOAD, 8'h10, 8'h10, "s4_load");
        op2(OP_INCR, 8'h00, 8'h14, "s4_incr");
        op2(OP_REL,  8'hF8, 8'h0C, "s4_rel_neg");
        op2(OP_REL,  8'h7F, 8'h8B, "s4_rel_pos");
        op2(OP_CALL, 8'h20, 8'h20, "s4_call");
        check("s4_tos", d2_tos, 8'h8F);
        op2(OP_RET,  8'h00, 8'h8F, "s4_ret");
        op2(OP_LOAD, 8'hFE, 8'hFE, "s4_load_fe");
        op2(OP_INCR, 8'h00, 8'h02, "s4_wrap");

        check("sb_drained", exp_q.size() + exp2_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_stack_reg.md
# pc_stack_reg

Parametrised program-counter register for the processor datapath: hold, load, increment by a configurable step, clear, PC-relative add, and subroutine call/return backed by an internal return-address stack. It replaces the fixed 8-bit increment register in the fetch stage. It also supplies the sequencer with stack status and sticky error flags.

## Interface
- `N`, 8, register and address width in bits (≥2)
- `STEP`, 1, increment amount added on INCR and pushed on CALL (0 < STEP < 2^N)
- `DEPTH`, 4, return-stack entries (power of two, ≥2)
- `clk`  input  1  single clock, all state updates on rising edge
- `clr`  input  1  reset; asynchronous, active-low
- `ctrl`  input  3  operation select, sampled every rising edge
- `in`  input  N  load value / call target / signed relative offset
- `out`  output  N  current PC value, registered
- `tos`  output  N  top-of-stack entry (0 when empty)
- `count`  output  clog2(DEPTH+1)  number of valid stack entries
- `empty`  output  1  count == 0
- `full`  output  1  count == DEPTH
- `ovf`  output  1  sticky: CALL attempted while full
- `unf`  output  1  sticky: RET attempted while empty

## Operation
- `ctrl` encoding:
  - 000 HOLD: out unchanged.
  - 001 LOAD: out ← in.
  - 010 INCR: out ← out + STEP.
  - 011 CLEAR: out ← 0; stack untouched.
  - 100 REL: out ← out + in, with `in` taken as N-bit two's complement.
  - 101 CALL: push (out + STEP), out ← in.
  - 110 RET: out ← popped entry.
  - 111 FLUSH: count ← 0, ovf ← 0, unf ← 0; out unchanged.
- All arithmetic is modulo 2^N; carries are discarded. 0xFF + 1 gives 0x00 at N=8.
- Stack is LIFO, implemented as an array plus count register. Entries above count are don't-care internally, but `tos` must read 0 when empty.
- CALL when full: no push, out unchanged, ovf ← 1. This is a full no-op apart from the flag.
- RET when empty: out unchanged, unf ← 1.
- ovf and unf stay set until FLUSH or reset. Other operations do not clear them.
- `empty`, `full` and `tos` are combinational decodes of registered state, with no added latency.
- Reset values: out = 0, count = 0, empty = 1, full = 0, tos = 0, ovf = 0, unf = 0. Stack array is cleared to 0.

## Timing
- Every operation completes in one cycle. The result is visible on `out`, `count` and `tos` immediately after the edge that samples `ctrl`.
- Back-to-back CALL/RET on consecutive cycles must work with no bubbles. RET directly after CALL returns the address pushed on the previous edge.
- Reset assertion (clr = 0) forces all reset values immediately, independent of clk, including mid-sequence.
- While clr = 0, all ctrl operations are ignored. The first operation after deassertion executes on the first rising edge with clr = 1.
- No input is registered; `ctrl` and `in` must be stable around the rising edge only.

## Test plan
- Reset/INCR wrap (N=8, STEP=1): release clr, LOAD 0xFE, then INCR ×3 → out = 0xFF, 0x00, 0x01. Assert clr mid-sequence → out = 0 with no clock edge.
- STEP and REL (N=8, STEP=4): LOAD 0x10, INCR → 0x14. REL in = 0xF8 (−8) → 0x0C. REL in = 0x7F → 0x8B.
- Nested call/return (DEPTH=4): LOAD 0x20, CALL 0x40 (push 0x21), CALL 0x60 (push 0x41). Expect count = 2, tos = 0x41. RET → out = 0x41. RET → out = 0x21, empty = 1, tos = 0.
- Overflow: five CALLs to 0x10, 0x20, 0x30, 0x40, 0x50 from out = 0. After the 4th: full = 1, out = 0x40. The 5th leaves out = 0x40, count = 4, ovf = 1. Subsequent INCR leaves ovf = 1.
- Underflow/flush: from empty, RET with out = 0x33 → out = 0x33, unf = 1. Then FLUSH → unf = 0, ovf = 0, count = 0, out = 0x33.
- Back-to-back: CALL 0x80 from out = 0x05, then RET on the next cycle → out = 0x06, count = 0. CLEAR between CALL and RET leaves count = 1 and RET still returns 0x06.
